// File: rtl/game_pkg.sv
// Shared types and IR command codes for the match flow controller and its frame timer.
package game_pkg;

  typedef enum logic [2:0] {
    SCR_START     = 3'd0,
    SCR_COUNTDOWN = 3'd1,
    SCR_FIGHT     = 3'd2,
    SCR_PAUSED    = 3'd3,
    SCR_ROUND_END = 3'd4,
    SCR_GAME_OVER = 3'd5
  } screen_t;

  typedef enum logic [1:0] {
    WIN_NONE     = 2'd0,
    WIN_PLAYER   = 2'd1,
    WIN_OPPONENT = 2'd2,
    WIN_DRAW     = 2'd3
  } winner_t;

  localparam logic [31:0] START_A = 32'h20DF_5BA4;
  localparam logic [31:0] START_B = 32'h20DF_5AA5;
  localparam logic [31:0] PAUSE   = 32'h20DF_10EF;

  function automatic logic is_start(input logic [31:0] code);
    return (code == START_A) || (code == START_B);
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] value);
    return (value == 2'd3) ? value : value + 2'd1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_flow_controller_frame_timer.sv
// Frame counter shared by countdown and round-end hold; done fires on the nf pulse that hits terminal.
module frame_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_in,
  input  logic             hold_in,
  input  logic             nf_in,
  input  logic [WIDTH-1:0] terminal_in,
  output logic             done_out
);

  logic [WIDTH-1:0] count;

  // done is combinational so the controller can register its reaction on the same edge
  assign done_out = nf_in && !hold_in && !clear_in && (count == terminal_in);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (clear_in || done_out) begin
      count <= '0;
    end else if (nf_in && !hold_in) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// Match sequencer: start, countdown, fight, pause, round-end hold and game-over, timed in frames.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int COUNT_FRAMES     = 60,
  parameter int ROUND_END_FRAMES = 120,
  parameter int ROUNDS_TO_WIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] ir_in,
  input  logic        ir_valid_in,
  input  logic        nf_in,
  input  logic [2:0]  player_health_in,
  input  logic [2:0]  opponent_health_in,
  output logic [2:0]  screen_out,
  output logic [1:0]  countdown_out,
  output logic        game_active_out,
  output logic        round_reset_out,
  output logic [1:0]  player_rounds_out,
  output logic [1:0]  opponent_rounds_out,
  output logic [1:0]  winner_out
);

  localparam int TW = $clog2(max2(max2(COUNT_FRAMES, ROUND_END_FRAMES), 2));
  localparam logic [TW-1:0] CD_TERM = TW'(COUNT_FRAMES - 1);
  localparam logic [TW-1:0] RE_TERM = TW'(ROUND_END_FRAMES - 1);
  localparam logic [1:0]    RTW     = 2'(ROUNDS_TO_WIN);

  screen_t state;
  winner_t winner;

  logic start_cmd, pause_cmd, player_ko, opponent_ko, knockout;
  logic timer_clear, timer_hold, timer_done;
  logic [TW-1:0] timer_term;

  assign start_cmd   = ir_valid_in && is_start(ir_in);
  assign pause_cmd   = ir_valid_in && (ir_in == PAUSE);
  assign player_ko   = (player_health_in == 3'd0);
  assign opponent_ko = (opponent_health_in == 3'd0);
  assign knockout    = nf_in && (player_ko || opponent_ko);

  // The timer only runs in COUNTDOWN and ROUND_END; elsewhere it sits at zero so each entry starts fresh.
  assign timer_clear = (state != SCR_COUNTDOWN) && (state != SCR_ROUND_END) && (state != SCR_PAUSED);
  assign timer_hold  = (state == SCR_PAUSED);
  assign timer_term  = (state == SCR_ROUND_END) ? RE_TERM : CD_TERM;

  frame_timer #(.WIDTH(TW)) u_timer (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (timer_clear),
    .hold_in     (timer_hold),
    .nf_in       (nf_in),
    .terminal_in (timer_term),
    .done_out    (timer_done)
  );

  assign screen_out = state;
  assign winner_out = winner;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= SCR_START;
      countdown_out       <= 2'd0;
      game_active_out     <= 1'b0;
      round_reset_out     <= 1'b0;
      player_rounds_out   <= 2'd0;
      opponent_rounds_out <= 2'd0;
      winner              <= WIN_NONE;
    end else begin
      round_reset_out <= 1'b0;
      case (state)
        SCR_START: begin
          if (start_cmd) begin
            state               <= SCR_COUNTDOWN;
            countdown_out       <= 2'd3;
            round_reset_out     <= 1'b1;
            player_rounds_out   <= 2'd0;
            opponent_rounds_out <= 2'd0;
            winner              <= WIN_NONE;
          end
        end
        SCR_COUNTDOWN: begin
          if (timer_done) begin
            if (countdown_out == 2'd1) begin
              state           <= SCR_FIGHT;
              countdown_out   <= 2'd0;
              game_active_out <= 1'b1;
            end else begin
              countdown_out <= countdown_out - 2'd1;
            end
          end
        end
        SCR_FIGHT: begin
          // A knockout on the same cycle as PAUSE takes priority; the pause is dropped.
          if (knockout) begin
            state           <= SCR_ROUND_END;
            game_active_out <= 1'b0;
            if (player_ko && opponent_ko) begin
              winner <= WIN_DRAW;
            end else if (player_ko) begin
              winner              <= WIN_OPPONENT;
              opponent_rounds_out <= sat_inc(opponent_rounds_out);
            end else begin
              winner            <= WIN_PLAYER;
              player_rounds_out <= sat_inc(player_rounds_out);
            end
          end else if (pause_cmd) begin
            state           <= SCR_PAUSED;
            game_active_out <= 1'b0;
          end
        end
        SCR_PAUSED: begin
          if (pause_cmd) begin
            state           <= SCR_FIGHT;
            game_active_out <= 1'b1;
          end
        end
        SCR_ROUND_END: begin
          if (timer_done) begin
            if ((player_rounds_out == RTW) || (opponent_rounds_out == RTW)) begin
              state <= SCR_GAME_OVER;
            end else begin
              state           <= SCR_COUNTDOWN;
              countdown_out   <= 2'd3;
              round_reset_out <= 1'b1;
              winner          <= WIN_NONE;
            end
          end
        end
        SCR_GAME_OVER: begin
          if (start_cmd) begin
            state               <= SCR_START;
            player_rounds_out   <= 2'd0;
            opponent_rounds_out <= 2'd0;
            winner              <= WIN_NONE;
          end
        end
        default: begin
          state           <= SCR_START;
          countdown_out   <= 2'd0;
          game_active_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench: stimulus pushes expected output snapshots, a negedge monitor pops and compares them.
module tb_game_flow_controller;

  localparam int CF  = 4;
  localparam int REF = 6;
  localparam int RTW = 2;

  localparam logic [31:0] C_START_A = 32'h20DF_5BA4;
  localparam logic [31:0] C_START_B = 32'h20DF_5AA5;
  localparam logic [31:0] C_PAUSE   = 32'h20DF_10EF;
  localparam logic [31:0] C_OTHER   = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir = 32'd0;
  logic        ir_valid = 1'b0;
  logic        nf = 1'b0;
  logic [2:0]  ph = 3'd7;
  logic [2:0]  oh = 3'd7;
  logic [2:0]  screen;
  logic [1:0]  countdown;
  logic        active;
  logic        rreset;
  logic [1:0]  prounds;
  logic [1:0]  orounds;
  logic [1:0]  winner;

  typedef struct {
    string      name;
    logic [13:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  game_flow_controller #(
    .COUNT_FRAMES(CF), .ROUND_END_FRAMES(REF), .ROUNDS_TO_WIN(RTW)
  ) dut (
    .clk_in(clk), .rst_in(rst), .ir_in(ir), .ir_valid_in(ir_valid), .nf_in(nf),
    .player_health_in(ph), .opponent_health_in(oh),
    .screen_out(screen), .countdown_out(countdown), .game_active_out(active),
    .round_reset_out(rreset), .player_rounds_out(prounds),
    .opponent_rounds_out(orounds), .winner_out(winner)
  );

  always #5 clk = ~clk;

  // {screen, countdown, active, round_reset, player_rounds, opponent_rounds, winner}
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [13:0] got;
      e   = exp_q.pop_front();
      got = {screen, countdown, active, rreset, prounds, orounds, 1'b0, winner};
      checks++;
      if (got === e.vec) passes++;
      else $display("FAIL %s: got scr=%0d cd=%0d act=%0d rr=%0d pr=%0d or=%0d win=%0d, expected scr=%0d cd=%0d act=%0d rr=%0d pr=%0d or=%0d win=%0d",
                    e.name, got[13:11], got[10:9], got[8], got[7], got[6:5], got[4:3], got[2:0],
                    e.vec[13:11], e.vec[10:9], e.vec[8], e.vec[7], e.vec[6:5], e.vec[4:3], e.vec[2:0]);
    end
  end

  task automatic expect_out(input string name, input int s, input int cd, input int act,
                            input int rr, input int pr, input int orr, input int w);
    exp_t e;
    e.name = name;
    e.vec  = {3'(s), 2'(cd), 1'(act), 1'(rr), 2'(pr), 2'(orr), 3'(w)};
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] code, input logic f);
    @(posedge clk); #1;
    rst = r; ir_valid = v; ir = code; nf = f;
    @(posedge clk); #1;
    rst = 1'b0; ir_valid = 1'b0; nf = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    expect_out("reset_values", 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, C_OTHER, 1'b1);
    expect_out("start_ignores_other_code", 0, 0, 0, 0, 0, 0, 0);

    step(1'b0, 1'b1, C_START_B, 1'b0);
    expect_out("start_b_enters_countdown", 1, 3, 0, 1, 0, 0, 0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    expect_out("round_reset_one_cycle", 1, 3, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, C_PAUSE, 1'b0);
    step(1'b0, 1'b1, C_START_A, 1'b0);
    expect_out("countdown_ignores_ir", 1, 3, 0, 0, 0, 0, 0);
    frames(3);
    expect_out("countdown_3_after_3f", 1, 3, 0, 0, 0, 0, 0);
    frames(1);
    expect_out("countdown_2", 1, 2, 0, 0, 0, 0, 0);
    frames(4);
    expect_out("countdown_1", 1, 1, 0, 0, 0, 0, 0);
    frames(3);
    expect_out("countdown_1_after_11f", 1, 1, 0, 0, 0, 0, 0);
    frames(1);
    expect_out("fight_after_12f", 2, 0, 1, 0, 0, 0, 0);

    oh = 3'd0;
    frames(1);
    oh = 3'd7;
    expect_out("opponent_ko", 4, 0, 0, 0, 1, 0, 1);
    frames(REF - 1);
    expect_out("round_end_holding", 4, 0, 0, 0, 1, 0, 1);
    frames(1);
    expect_out("round_end_to_countdown", 1, 3, 0, 1, 1, 0, 0);
    frames(3 * CF);
    expect_out("fight_round2", 2, 0, 1, 0, 1, 0, 0);

    ph = 3'd0; oh = 3'd0;
    frames(1);
    ph = 3'd7; oh = 3'd7;
    expect_out("double_ko_draw", 4, 0, 0, 0, 1, 0, 3);
    frames(REF);
    expect_out("draw_to_countdown", 1, 3, 0, 1, 1, 0, 0);
    frames(3 * CF);

    ph = 3'd0;
    step(1'b0, 1'b1, C_PAUSE, 1'b1);
    ph = 3'd7;
    expect_out("ko_beats_pause", 4, 0, 0, 0, 1, 1, 2);
    frames(REF);
    frames(3 * CF);
    expect_out("fight_round4", 2, 0, 1, 0, 1, 1, 0);

    step(1'b0, 1'b1, C_PAUSE, 1'b0);
    expect_out("pause_entered", 3, 0, 0, 0, 1, 1, 0);
    ph = 3'd0; oh = 3'd0;
    frames(50);
    expect_out("paused_ignores_frames", 3, 0, 0, 0, 1, 1, 0);
    step(1'b0, 1'b1, C_START_A, 1'b1);
    expect_out("paused_ignores_start", 3, 0, 0, 0, 1, 1, 0);
    step(1'b0, 1'b1, C_PAUSE, 1'b0);
    ph = 3'd7; oh = 3'd7;
    expect_out("unpause_to_fight", 2, 0, 1, 0, 1, 1, 0);

    oh = 3'd0;
    frames(1);
    oh = 3'd7;
    expect_out("player_match_point", 4, 0, 0, 0, 2, 1, 1);
    frames(REF);
    expect_out("game_over", 5, 0, 0, 0, 2, 1, 1);
    step(1'b0, 1'b1, C_START_A, 1'b0);
    expect_out("game_over_to_start", 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, C_START_A, 1'b0);
    expect_out("new_match_countdown", 1, 3, 0, 1, 0, 0, 0);
    frames(CF + 1);
    expect_out("mid_countdown", 1, 2, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1, C_START_B, 1'b1);
    expect_out("reset_mid_countdown", 0, 0, 0, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    if (checks == 0) $display("FAIL no_checks: no comparisons were performed");
    if (passes != checks) $display("FAIL summary: %0d of %0d checks failed", checks - passes, checks);
    if (exp_q.size() != 0) $display("FAIL queue: %0d expectations never compared", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before it");
    $fatal(1);
  end

endmodule
